axi_lite_dram_slave: RTL
========================

AXI_LITE_DRAM_SLAVE -- requirements
Module: axi_lite_dram_slave

Interface
REQ-001 Parameter RD_LAT, default 2: idle cycles between AR handshake and R_VALID rise, range 0..15.
REQ-002 Parameter DEPTH, default 256: number of 64-bit memory words, indexed by addr[10:3].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 AR_VALID  input  1  read address valid.
REQ-006 AR_ADDR  input  17  read byte address.
REQ-007 AR_READY  output  1  read address accepted.
REQ-008 R_VALID  output  1  read data valid.
REQ-009 R_DATA  output  64  read data.
REQ-010 R_RESP  output  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-011 R_READY  input  1  master accepts read data.
REQ-012 AW_VALID  input  1  write address valid.
REQ-013 AW_ADDR  input  17  write byte address.
REQ-014 AW_READY  output  1  write address accepted.
REQ-015 W_VALID  input  1  write data valid.
REQ-016 W_DATA  input  64  write data.
REQ-017 W_READY  output  1  write data accepted.
REQ-018 B_VALID  output  1  write response valid.
REQ-019 B_RESP  output  2  write response, same encoding as R_RESP.
REQ-020 B_READY  input  1  master accepts write response.

Function
REQ-021 FSM states IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_RESP; one transaction in flight at a time.
REQ-022 Valid address: addr[16:11]==6'b100000 and addr[2:0]==3'b000, word index addr[10:3]; any other address is invalid.
REQ-023 IDLE: AR_READY = AR_VALID (combinational); AW_READY = AW_VALID & ~AR_VALID; both 0 in all other states.
REQ-024 Simultaneous AR_VALID and AW_VALID in IDLE: read wins; write address stays pending until the next IDLE.
REQ-025 AR handshake: latch address, load latency counter with RD_LAT, go to RD_WAIT; RD_LAT==0 goes directly to RD_RESP.
REQ-026 RD_WAIT: counter decrements each cycle; at 1 go to RD_RESP; R_DATA registered from mem[index] on entering RD_RESP.
REQ-027 RD_RESP: R_VALID=1; R_DATA/R_RESP held stable until R_READY; return to IDLE on the cycle after R_VALID&R_READY.
REQ-028 Invalid read address: R_DATA=64'd0, R_RESP=SLVERR; memory unchanged.
REQ-029 AW handshake: latch address, go to WR_DATA; W_READY = W_VALID in WR_DATA.
REQ-030 W handshake: on that edge write W_DATA to mem[index] if address valid, otherwise discard; go to WR_RESP.
REQ-031 WR_RESP: B_VALID=1, B_RESP OKAY/SLVERR per address; held until B_READY; return to IDLE after B_VALID&B_READY.
REQ-032 B_READY asserted before B_VALID: response completes on the first WR_RESP cycle (1-cycle B_VALID pulse).
REQ-033 Read-after-write to the same index returns the newly written data.
REQ-034 R_DATA field layout is opaque; 64-bit words are stored and returned unmodified.
REQ-035 Minimum read turnaround: AR handshake to R_VALID = RD_LAT+1 cycles; write: W handshake to B_VALID = 1 cycle.

Reset
REQ-036 rst_n low at a clock edge: state IDLE; AR_READY, R_VALID, AW_READY, W_READY, B_VALID = 0; R_DATA = 0; R_RESP, B_RESP = 2'b00.
REQ-037 Reset mid-transaction aborts it with no response; a write with W handshake not yet completed does not modify memory.
REQ-038 Memory contents are not reset; they persist across rst_n.

Verification
REQ-039 Write AW_ADDR=17'h10040, W_DATA=64'h123_456_07_789_ABC_1F -> B_VALID one cycle after W handshake, B_RESP=00; read 17'h10040 with RD_LAT=2 -> R_VALID 3 cycles after AR handshake, same data, R_RESP=00.
REQ-040 AR_VALID and AW_VALID raised same cycle (addr 17'h10008) -> AR_READY=1, AW_READY=0; read completes first, then AW_READY=1 in the following IDLE.
REQ-041 Read 17'h00040 (bad prefix) and write 17'h10044 (misaligned) -> R_DATA=0, R_RESP=10; B_RESP=10, mem[8] unchanged.
REQ-042 R_READY held low 5 cycles after R_VALID -> R_VALID and R_DATA stable all 5 cycles; IDLE on the cycle after R_READY rises.
REQ-043 rst_n low in RD_WAIT and again in WR_DATA -> all outputs 0 the following cycle, no R_VALID/B_VALID, previously written data still readable.
REQ-044 RD_LAT=0 with B_READY held high from WR_DATA -> R_VALID one cycle after AR handshake; B_VALID single-cycle pulse.

Source files
------------

// File: rtl/axi_lite_dram_slave.sv
`timescale 1ns/1ps
// axi_lite_dram_slave
//   AXI-Lite style slave in front of a DEPTH x 64-bit word memory. One
//   transaction is in flight at a time. Reads see RD_LAT idle cycles between
//   the AR handshake and R_VALID. Writes respond one cycle after the W
//   handshake.
//   Valid address: addr[16:11] == 6'b100000 and addr[2:0] == 3'b000, with the
//   word index in addr[10:3]. Any other address returns SLVERR. A read of an
//   invalid address returns zero data; a write to one is discarded.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   AR_VALID/AR_ADDR/AR_READY   read address channel
//   R_VALID/R_DATA/R_RESP       read data channel (R_READY from the master)
//   AW_VALID/AW_ADDR/AW_READY   write address channel
//   W_VALID/W_DATA/W_READY      write data channel
//   B_VALID/B_RESP/B_READY      write response channel
//
// The memory array is never reset, so its contents persist across rst_n.
module axi_lite_dram_slave #(
  parameter int RD_LAT = 2,    // 0..15
  parameter int DEPTH  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        AR_VALID,
  input  logic [16:0] AR_ADDR,
  output logic        AR_READY,
  output logic        R_VALID,
  output logic [63:0] R_DATA,
  output logic [1:0]  R_RESP,
  input  logic        R_READY,
  input  logic        AW_VALID,
  input  logic [16:0] AW_ADDR,
  output logic        AW_READY,
  input  logic        W_VALID,
  input  logic [63:0] W_DATA,
  output logic        W_READY,
  output logic        B_VALID,
  output logic [1:0]  B_RESP,
  input  logic        B_READY
);

  localparam int         IDX_W       = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] LAT_INIT    = 4'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_RESP,
    S_WR_DATA,
    S_WR_RESP
  } state_t;

  function automatic logic addr_ok(input logic [5:0] prefix, input logic [2:0] low);
    return (prefix == 6'b100000) && (low == 3'b000);
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [16:0]       r_addr;
  logic [63:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic [1:0]        r_bresp;
  logic [63:0]       r_mem [DEPTH];

  logic              w_load_r;
  logic              w_w_hs;
  logic              w_wr_en;
  logic [16:0]       w_rd_addr;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;

  // With RD_LAT == 0 the read data is loaded straight out of IDLE, before the
  // address register holds the new address, so the read path looks at AR_ADDR
  // while idle and at the latched address afterwards.
  assign w_rd_addr = (r_state == S_IDLE) ? AR_ADDR : r_addr;
  assign w_rd_ok   = addr_ok(w_rd_addr[16:11], w_rd_addr[2:0]);
  assign w_rd_idx  = w_rd_addr[3 +: IDX_W];
  assign w_wr_ok   = addr_ok(r_addr[16:11], r_addr[2:0]);
  assign w_wr_idx  = r_addr[3 +: IDX_W];

  assign w_w_hs    = (r_state == S_WR_DATA) && W_VALID;
  // A reset that lands on the W handshake edge aborts the write.
  assign w_wr_en   = w_w_hs && w_wr_ok && rst_n;

  assign R_DATA    = r_rdata;
  assign R_RESP    = r_rresp;
  assign B_RESP    = r_bresp;

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    AR_READY    = 1'b0;
    AW_READY    = 1'b0;
    W_READY     = 1'b0;
    R_VALID     = 1'b0;
    B_VALID     = 1'b0;
    w_load_r    = 1'b0;
    case (r_state)
      S_IDLE: begin
        AR_READY = AR_VALID;
        // The read wins a tie; the write address stays pending until the
        // next IDLE.
        AW_READY = AW_VALID & ~AR_VALID;
        if (AR_VALID) begin
          if (RD_LAT == 0) begin
            w_state_nxt = S_RD_RESP;
            w_load_r    = 1'b1;
          end else begin
            w_state_nxt = S_RD_WAIT;
          end
        end else if (AW_VALID) begin
          w_state_nxt = S_WR_DATA;
        end
      end
      S_RD_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_RD_RESP;
          w_load_r    = 1'b1;
        end
      end
      S_RD_RESP: begin
        R_VALID = 1'b1;
        if (R_READY) w_state_nxt = S_IDLE;
      end
      S_WR_DATA: begin
        W_READY = W_VALID;
        if (W_VALID) w_state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        B_VALID = 1'b1;
        if (B_READY) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 64'd0;
      r_rresp <= RESP_OKAY;
      r_bresp <= RESP_OKAY;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        r_cnt <= LAT_INIT;
      end else if (r_state == S_RD_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Read data and response are captured on the edge entering RD_RESP
      // and then held until the R handshake.
      if (w_load_r) begin
        r_rdata <= w_rd_ok ? r_mem[w_rd_idx] : 64'd0;
        r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (w_w_hs) begin
        r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Address latch (only meaningful once a handshake has moved us out of IDLE)
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE) begin
      r_addr <= AR_VALID ? AR_ADDR : AW_ADDR;
    end
  end

  // Memory array
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= W_DATA;
    end
  end

endmodule
